// File: rtl/dut_bus_source.sv
// Memory-mapped byte source: a producer pushes bytes over valid/ready, the CPU drains them
// through a DATA register and observes occupancy/underflow through a STATUS register.
module dut_bus_source #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        re,
    output logic [31:0] rd,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_underflow;
    logic          r_re_data_q;

    logic w_empty;
    logic w_full;
    logic w_data_rd;
    logic w_first_rd;
    logic w_push;
    logic w_pop;
    logic w_flush;
    logic w_uf_set;
    logic w_uf_clr;
    logic w_unused;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign in_ready   = !w_full && !reset;
    assign w_push     = in_valid && in_ready;

    // Only the first cycle of a (possibly multicycle) DATA load consumes a byte.
    assign w_data_rd  = re && !addr[2];
    assign w_first_rd = w_data_rd && !r_re_data_q;
    assign w_flush    = we && addr[2] && wd[0];
    assign w_uf_clr   = we && addr[2] && wd[2];
    assign w_pop      = w_first_rd && !w_empty && !w_flush;
    assign w_uf_set   = w_first_rd && w_empty;
    assign w_unused   = ^{addr[29:3], addr[1:0], wd[31:3], wd[1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
            r_re_data_q <= 1'b0;
        end else begin
            r_re_data_q <= w_data_rd;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            // Flush moves the head to the old write pointer, so a same-cycle push becomes the head.
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_flush) begin
                r_count <= w_push ? CW'(1) : '0;
            end else if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_uf_set) begin
                r_underflow <= 1'b1;
            end else if (w_uf_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_comb begin
        rd = '0;
        if (addr[2]) begin
            rd[0]    = w_empty;
            rd[1]    = w_full;
            rd[2]    = r_underflow;
            rd[15:8] = 8'(r_count);
        end else if (!w_empty) begin
            rd = {23'b0, 1'b1, r_mem[r_rd_ptr]};
        end
    end

endmodule
